prewish_blinky_multi: RTL

Parametrised multi-channel successor to the single-LED pattern blinker. Holds NCH independent PAT_BITS-wide blink patterns, rotates all of them on a shared prescaler tick, and drives one LED per channel. Patterns and a small control register are written (and optionally read back) through a Wishbone-style slave port with single-cycle ACK_O. It sits between the bus master and the board LEDs.

---
 rtl/prewish_blinky_multi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/prewish_blinky_multi.sv
// prewish_blinky_multi
// Multi-channel LED pattern blinker with a Wishbone-style slave port.
// NCH independent PAT_BITS-wide patterns rotate left on a shared prescaler
// tick. Each LED is driven by the MSB of its channel's pattern register.
//
// Register map (ADR_I):
//   0 .. NCH-1 : pattern of channel ADR_I
//   NCH        : CTRL  (write: bit0 RUN, bit1 RESYNC strobe; read: {0.., RUN})
//   above      : unmapped (writes ignored, reads return 0, always acked)
//
// Build option: define PREWISH_BLINKY_READBACK_EN to enable the read data
// path. Without it DAT_O stays 0, while reads are still acknowledged.
module prewish_blinky_multi #(
    parameter int NCH      = 4,
    parameter int PAT_BITS = 8,
    parameter int DIV_BITS = 22,
    parameter int ADR_BITS = 3
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                STB_I,
    input  logic                WE_I,
    input  logic [ADR_BITS-1:0] ADR_I,
    input  logic [PAT_BITS-1:0] DAT_I,
    output logic [PAT_BITS-1:0] DAT_O,
    output logic                ACK_O,
    output logic [NCH-1:0]      o_led
);

    // Address of the control register, directly after the pattern slots.
    localparam logic [ADR_BITS-1:0] CTRL_ADR = ADR_BITS'(NCH);

    // Prescaler increment and terminal value, sized to the counter.
    localparam logic [DIV_BITS-1:0] CNT_ONE  = {{(DIV_BITS-1){1'b0}}, 1'b1};
    localparam logic [DIV_BITS-1:0] CNT_LAST = {DIV_BITS{1'b1}};

    // One-step left rotation; the MSB wraps around into bit 0.
    function automatic logic [PAT_BITS-1:0] rotl(input logic [PAT_BITS-1:0] v);
        return {v[PAT_BITS-2:0], v[PAT_BITS-1]};
    endfunction

    // State registers and their next-state values.
    logic [PAT_BITS-1:0] pat_q [NCH];
    logic [PAT_BITS-1:0] pat_d [NCH];
    logic                run_q;
    logic                run_d;
    logic [DIV_BITS-1:0] cnt_q;
    logic [DIV_BITS-1:0] cnt_d;
    logic                ack_q;
    logic                ack_d;
    logic [PAT_BITS-1:0] dat_q;
    logic [PAT_BITS-1:0] dat_d;

    // Decoded strobes for the current cycle.
    logic accept_s;
    logic wr_s;
    logic ctrl_wr_s;
    logic resync_s;
    logic tick_s;

    // Bus handshake decode and prescaler tick detection.
    always_comb begin
        // A transfer is taken only while no acknowledge is pending, so a
        // strobe held high is served on every second cycle.
        accept_s  = STB_I & ~ack_q;
        wr_s      = accept_s & WE_I;
        ctrl_wr_s = wr_s & (ADR_I == CTRL_ADR);
        resync_s  = ctrl_wr_s & DAT_I[1];
        tick_s    = run_q & (cnt_q == CNT_LAST);
    end

    // Next RUN flag, prescaler count and acknowledge.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        ack_d = accept_s;

        if (ctrl_wr_s) begin
            run_d = DAT_I[0];
        end else begin
            run_d = run_q;
        end

        // RESYNC takes priority over counting; counting follows the RUN
        // value in force before this edge, and wraps naturally at all-ones.
        if (resync_s) begin
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next pattern per channel: a bus write beats a coincident rotation.
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            if (wr_s && (ADR_I == ADR_BITS'(n))) begin
                pat_d[n] = DAT_I;
            end else if (tick_s) begin
                pat_d[n] = rotl(pat_q[n]);
            end else begin
                pat_d[n] = pat_q[n];
            end
        end
    end

`ifdef PREWISH_BLINKY_READBACK_EN
    logic                rd_s;
    logic [PAT_BITS-1:0] rd_data_s;

    // Read mux; the selected value is captured so it appears with ACK_O.
    always_comb begin
        rd_s      = accept_s & ~WE_I;
        rd_data_s = '0;
        for (int n = 0; n < NCH; n++) begin
            if (ADR_I == ADR_BITS'(n)) begin
                rd_data_s = pat_q[n];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
        if (ADR_I == CTRL_ADR) begin
            rd_data_s = {{(PAT_BITS-1){1'b0}}, run_q};
        end else begin
            rd_data_s = rd_data_s;
        end

        // Read data is non-zero only in the acknowledge cycle of a read.
        if (rd_s) begin
            dat_d = rd_data_s;
        end else begin
            dat_d = '0;
        end
    end
`else
    // Read data path absent: the data output stays at zero.
    always_comb begin
        dat_d = '0;
    end
`endif

    // State update with synchronous active-low reset.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            for (int n = 0; n < NCH; n++) begin
                pat_q[n] <= '0;
            end
            run_q <= 1'b1;
            cnt_q <= '0;
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                pat_q[n] <= pat_d[n];
            end
            run_q <= run_d;
            cnt_q <= cnt_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    // Outputs come straight from registers; LEDs show each pattern's MSB.
    assign ACK_O = ack_q;
    assign DAT_O = dat_q;

    for (genvar g = 0; g < NCH; g++) begin : g_led
        assign o_led[g] = pat_q[g][PAT_BITS-1];
    end

endmodule
